// File: rtl/dcs_sink_pkg.sv
// ============================================================================
// dcs_sink_pkg : DCS opcodes and decoder state encodings for dcs_sink
// Rev 1.0
// ============================================================================
`default_nettype none

package dcs_sink_pkg;

  localparam logic [7:0] c_dcs_swreset = 8'h01;
  localparam logic [7:0] c_dcs_caset   = 8'h2A;
  localparam logic [7:0] c_dcs_raset   = 8'h2B;
  localparam logic [7:0] c_dcs_ramwr   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_RASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_SKIP  = 3'd4
  } dcs_state_t;

endpackage

`default_nettype wire

// File: rtl/dcs_sink_spi_byte_rx.sv
// ============================================================================
// spi_byte_rx : oversampling SPI mode-0 byte deserialiser with D/C tag
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_byte_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       sck,
  input  logic       dc,
  input  logic       mosi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic       r_cs_meta, r_cs_sync;
  logic       r_sck_meta, r_sck_sync, r_sck_prev;
  logic       r_dc_meta, r_dc_sync;
  logic       r_mosi_meta, r_mosi_sync;
  logic       r_edge, r_edge_mosi, r_edge_dc;
  logic [6:0] r_shift;
  logic [2:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_sck_meta  <= 1'b0;
      r_sck_sync  <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_dc_meta   <= 1'b0;
      r_dc_sync   <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_edge      <= 1'b0;
      r_edge_mosi <= 1'b0;
      r_edge_dc   <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      byte_dc     <= 1'b0;
    end else begin
      r_cs_meta   <= cs_n;
      r_cs_sync   <= r_cs_meta;
      r_sck_meta  <= sck;
      r_sck_sync  <= r_sck_meta;
      r_sck_prev  <= r_sck_sync;
      r_dc_meta   <= dc;
      r_dc_sync   <= r_dc_meta;
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
      // mosi and dc are captured alongside the edge flag so they stay aligned
      r_edge      <= r_sck_sync & ~r_sck_prev & ~r_cs_sync;
      r_edge_mosi <= r_mosi_sync;
      r_edge_dc   <= r_dc_sync;
      byte_valid  <= 1'b0;
      if (r_cs_sync) begin
        r_cnt <= '0;
      end else if (r_edge) begin
        r_shift <= {r_shift[5:0], r_edge_mosi};
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {r_shift, r_edge_mosi};
          byte_dc    <= r_edge_dc;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcs_sink.sv
// ============================================================================
// dcs_sink : DCS command decoder with windowed RGB565 pixel-write output
// Rev 1.0
// ============================================================================
`default_nettype none

module dcs_sink
  import dcs_sink_pkg::*;
#(
  parameter int AW     = 9,
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cs_n,
  input  logic          sck,
  input  logic          dc,
  input  logic          mosi,
  output logic          cmd_valid,
  output logic [7:0]    cmd,
  output logic          pixel_valid,
  output logic [AW-1:0] x,
  output logic [AW-1:0] y,
  output logic [15:0]   color
);

  localparam logic [AW-1:0] c_xe_def = AW'(WIDTH - 1);
  localparam logic [AW-1:0] c_ye_def = AW'(HEIGHT - 1);
  localparam logic [AW-1:0] c_one    = AW'(1);

  logic          w_byte_valid;
  logic [7:0]    w_byte;
  logic          w_byte_dc;
  logic [AW-1:0] w_coord;

  dcs_state_t    r_state, w_state_nx;
  logic [1:0]    r_idx, w_idx_nx;
  logic [AW-1:0] r_xs, r_xe, r_ys, r_ye;
  logic [AW-1:0] r_new_s;
  logic [7:0]    r_par_hi;
  logic [AW-1:0] r_cx, r_cy;
  logic          r_half;
  logic [7:0]    r_hi;

  spi_byte_rx u_rx (
    .clock      (clock),
    .reset      (reset),
    .cs_n       (cs_n),
    .sck        (sck),
    .dc         (dc),
    .mosi       (mosi),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte),
    .byte_dc    (w_byte_dc)
  );

  assign w_coord = AW'({r_par_hi, w_byte});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    if (w_byte_valid) begin
      if (!w_byte_dc) begin
        w_idx_nx = '0;
        case (w_byte)
          c_dcs_caset:   w_state_nx = ST_CASET;
          c_dcs_raset:   w_state_nx = ST_RASET;
          c_dcs_ramwr:   w_state_nx = ST_RAMWR;
          c_dcs_swreset: w_state_nx = ST_IDLE;
          default:       w_state_nx = ST_SKIP;
        endcase
      end else if (r_state == ST_CASET || r_state == ST_RASET) begin
        if (r_idx == 2'd3) begin
          w_state_nx = ST_IDLE;
        end
        w_idx_nx = r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      cmd         <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      color       <= '0;
      r_xs        <= '0;
      r_xe        <= c_xe_def;
      r_ys        <= '0;
      r_ye        <= c_ye_def;
      r_new_s     <= '0;
      r_par_hi    <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_half      <= 1'b0;
      r_hi        <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      if (w_byte_valid && !w_byte_dc) begin
        cmd_valid <= 1'b1;
        cmd       <= w_byte;
        r_half    <= 1'b0;
        if (w_byte == c_dcs_ramwr) begin
          r_cx <= r_xs;
          r_cy <= r_ys;
        end
        if (w_byte == c_dcs_swreset) begin
          r_xs <= '0;
          r_xe <= c_xe_def;
          r_ys <= '0;
          r_ye <= c_ye_def;
        end
      end else if (w_byte_valid) begin
        case (r_state)
          ST_CASET, ST_RASET: begin
            // start/end are staged and committed together on the last byte
            case (r_idx)
              2'd1:    r_new_s  <= w_coord;
              2'd3: begin
                if (r_state == ST_CASET) begin
                  r_xs <= r_new_s;
                  r_xe <= w_coord;
                end else begin
                  r_ys <= r_new_s;
                  r_ye <= w_coord;
                end
              end
              default: r_par_hi <= w_byte;
            endcase
          end
          ST_RAMWR: begin
            if (!r_half) begin
              r_hi   <= w_byte;
              r_half <= 1'b1;
            end else begin
              r_half      <= 1'b0;
              pixel_valid <= 1'b1;
              x           <= r_cx;
              y           <= r_cy;
              color       <= {r_hi, w_byte};
              if (r_cx == r_xe) begin
                r_cx <= r_xs;
                r_cy <= (r_cy == r_ye) ? r_ys : r_cy + c_one;
              end else begin
                r_cx <= r_cx + c_one;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
